// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encoding and sizing constants for the instruction memory loader
package imem_loader_pkg;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  localparam int DEPTH_DEF = 1024;
  localparam int LANES = 4;
  localparam int LANE_W = $clog2(LANES);
  localparam int WC_W = 11;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, instruction memory write port out
interface imem_loader_if;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_data;
  logic mem_writeEnable;
  logic [31:0] mem_address;
  logic [31:0] mem_dataIn;
  modport master (output in_valid, in_data, input in_ready, mem_writeEnable, mem_address, mem_dataIn);
  modport slave (input in_valid, in_data, output in_ready, mem_writeEnable, mem_address, mem_dataIn);
endinterface

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: little-endian byte lane counter and 32-bit word assembler
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0] word_q, word_d;
  always_comb begin
    lane_d = clear ? '0 : accept ? lane_q + 1'b1 : lane_q;
    word_d = word_q;
    if (accept) word_d[{lane_q, 3'b000} +: 8] = byte_in;
  end
  assign word = word_d;
  assign word_valid = accept && lane_q == LANE_W'(LANES - 1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into the instruction memory as little-endian words while holding the CPU
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [WC_W-1:0] word_count,
  output logic            busy,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  imem_loader_if.slave    bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [WC_W-1:0] DEPTH_W = WC_W'(DEPTH);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [WC_W-1:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d, word;
  logic error_q, error_d, clear, accept, word_valid, last;
  assign accept = bus.in_valid && bus.in_ready;
  imem_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .accept     (accept),
    .byte_in    (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    error_d = 1'b0;
    clear = 1'b0;
    last = WC_W'(idx_q) == cnt_q - 1'b1;
    case (state_q)
      IDLE: if (start) begin
        if (word_count != '0 && word_count <= DEPTH_W) begin
          state_d = RECV;
          cnt_d = word_count;
          idx_d = '0;
          clear = 1'b1;
        end else error_d = 1'b1;
      end
      RECV: if (word_valid) begin
        state_d = WRITE;
        addr_d = idx_q;
        data_d = word;
      end
      // index holds on the final word so it never reaches DEPTH
      WRITE: begin
        state_d = last ? DONE : RECV;
        idx_d = last ? idx_q : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      error_q <= error_d;
    end
  end
  assign bus.in_ready = state_q == RECV;
  assign bus.mem_writeEnable = state_q == WRITE;
  assign bus.mem_address = 32'(addr_q);
  assign bus.mem_dataIn = data_q;
  assign busy = state_q != IDLE;
  assign cpu_hold = busy;
  assign done = state_q == DONE;
  assign error = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [10:0] word_count = '0;
  logic busy, cpu_hold, done, error;
  int n_tests = 0;
  int n_fail = 0;
  int ncyc = 0;
  int last_acc = 0;
  int last_we = 0;
  int last_done = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic addr_over = 1'b0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] exp_w[$];
  imem_loader_if bus ();
  imem_loader #(.DEPTH(1024)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .word_count (word_count),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .bus        (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    ncyc++;
    if (bus.in_valid && bus.in_ready) last_acc = ncyc;
    if (bus.mem_writeEnable) begin
      wa.push_back(bus.mem_address);
      wd.push_back(bus.mem_dataIn);
      last_we = ncyc;
      if (bus.mem_address >= 32'd1024) addr_over = 1'b1;
    end
    if (done) begin
      done_cnt++;
      last_done = ncyc;
    end
    if (error) err_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt = 0;
    err_cnt = 0;
  endtask
  task automatic pulse_start(input logic [10:0] n);
    start = 1'b1;
    word_count = n;
    tick();
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data = b;
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    if (!bus.in_ready) check("ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
    check({tag, "_we"}, {31'b0, bus.mem_writeEnable}, 32'd0);
    check({tag, "_addr"}, bus.mem_address, 32'd0);
    check({tag, "_data"}, bus.mem_dataIn, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_hold"}, {31'b0, cpu_hold}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_error"}, {31'b0, error}, 32'd0);
  endtask
  initial begin
    int bad;
    logic [31:0] w;
    logic [7:0] b;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (2) tick();
    check_idle_outputs("rst");
    reset_n = 1'b1;
    tick();
    // single word, back-to-back bytes, latency
    clear_log();
    pulse_start(11'd1);
    check("w1_busy", {31'b0, busy}, 32'd1);
    check("w1_hold", {31'b0, cpu_hold}, 32'd1);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (5) tick();
    check("w1_strobes", wa.size(), 32'd1);
    check("w1_addr", wa[0], 32'd0);
    check("w1_data", wd[0], 32'h00000013);
    check("w1_we_lat", last_we - last_acc, 32'd1);
    check("w1_done_lat", last_done - last_acc, 32'd2);
    check("w1_done_cnt", done_cnt, 32'd1);
    check("w1_idle_busy", {31'b0, busy}, 32'd0);
    // three words with valid gaps
    clear_log();
    pulse_start(11'd3);
    for (int i = 0; i < 12; i++) send_byte(8'(i), i % 4);
    repeat (5) tick();
    check("w3_strobes", wa.size(), 32'd3);
    check("w3_a0", wa[0], 32'd0);
    check("w3_d0", wd[0], 32'h03020100);
    check("w3_a1", wa[1], 32'd1);
    check("w3_d1", wd[1], 32'h07060504);
    check("w3_a2", wa[2], 32'd2);
    check("w3_d2", wd[2], 32'h0B0A0908);
    check("w3_done_cnt", done_cnt, 32'd1);
    // illegal word counts
    clear_log();
    pulse_start(11'd0);
    check("err0_pulse", {31'b0, error}, 32'd1);
    check("err0_busy", {31'b0, busy}, 32'd0);
    tick();
    check("err0_clear", {31'b0, error}, 32'd0);
    pulse_start(11'd1025);
    check("err1025_pulse", {31'b0, error}, 32'd1);
    check("err1025_busy", {31'b0, busy}, 32'd0);
    repeat (3) tick();
    check("err_cnt", err_cnt, 32'd2);
    check("err_strobes", wa.size(), 32'd0);
    check("err_ready", {31'b0, bus.in_ready}, 32'd0);
    // reset in the middle of a load
    clear_log();
    pulse_start(11'd2);
    for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), 0);
    clear_log();
    reset_n = 1'b0;
    tick();
    check_idle_outputs("mid_rst");
    reset_n = 1'b1;
    repeat (4) tick();
    check("mid_rst_strobes", wa.size(), 32'd0);
    check("mid_rst_done", done_cnt, 32'd0);
    pulse_start(11'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 2);
    repeat (5) tick();
    check("post_rst_strobes", wa.size(), 32'd1);
    check("post_rst_addr", wa[0], 32'd0);
    check("post_rst_data", wd[0], 32'hDDCCBBAA);
    // start while busy is ignored
    clear_log();
    pulse_start(11'd2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_start(11'd5);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    pulse_start(11'd0);
    for (int i = 0; i < 4; i++) send_byte(8'h55 + 8'(i), 0);
    repeat (5) tick();
    check("busy_start_strobes", wa.size(), 32'd2);
    check("busy_start_d0", wd[0], 32'h44332211);
    check("busy_start_a1", wa[1], 32'd1);
    check("busy_start_d1", wd[1], 32'h58575655);
    check("busy_start_done", done_cnt, 32'd1);
    check("busy_start_err", err_cnt, 32'd0);
    // full-depth load against a scoreboard
    clear_log();
    exp_w.delete();
    addr_over = 1'b0;
    pulse_start(11'd1024);
    for (int i = 0; i < 1024; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom_range(0, 255));
        w[k*8 +: 8] = b;
        send_byte(b, 0);
      end
      exp_w.push_back(w);
    end
    repeat (5) tick();
    check("full_strobes", wa.size(), 32'd1024);
    bad = 0;
    for (int i = 0; i < 1024 && i < wa.size(); i++)
      if (wa[i] !== 32'(i) || wd[i] !== exp_w[i]) bad++;
    check("full_mismatch_cnt", bad, 32'd0);
    check("full_addr_over", {31'b0, addr_over}, 32'd0);
    check("full_done", done_cnt, 32'd1);
    check("full_err", err_cnt, 32'd0);
    check("full_idle", {31'b0, busy}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
